// File: rtl/clock_phase_gen.sv
// clock_phase_gen: divided reference clock (period 2*H, 50% duty) plus a copy
// lagging it by Ph system-clock cycles. New settings are applied only on a
// period boundary, or while idle, so neither waveform ever shows a runt pulse.
//
// Config handshake: a transfer occurs on any rising edge where cfg_valid and
// cfg_ready are both high. An accepted (legal) setting drops cfg_ready until it
// is applied. A rejected one raises cfg_err for one cycle and leaves cfg_ready
// high. cfg_valid while cfg_ready is low is ignored.
module clock_phase_gen #(
  parameter int CNT_W     = 8,
  parameter int DEF_HALF  = 4,
  parameter int DEF_PHASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_half,
  input  logic [CNT_W:0]   cfg_phase,
  output logic             cfg_err,
  output logic             ref_clk,
  output logic             phased_clk,
  output logic             period_start,
  output logic             locked,
  output logic             state_dbg
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DEF_H = CNT_W'(DEF_HALF);
  localparam logic [CNT_W:0]   DEF_P = (CNT_W+1)'(DEF_PHASE);
  localparam logic [CNT_W:0]   ONE   = (CNT_W+1)'(1);

  state_t                state_q, state_d;
  logic [CNT_W:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]      half_q, half_d;
  logic [CNT_W:0]        phase_q, phase_d;
  logic [CNT_W-1:0]      pend_half_q, pend_half_d;
  logic [CNT_W:0]        pend_phase_q, pend_phase_d;
  logic                  ready_d, err_d, ref_d, phased_d, start_d, locked_d;

  logic                  cfg_ok, pending, wrap, apply;
  logic [CNT_W:0]        period, cnt_nx;
  logic [CNT_W-1:0]      use_half;
  logic [CNT_W:0]        use_phase, use_period;
  logic signed [CNT_W+1:0] diff;

  assign state_dbg = state_q;

  // Next-state, handshake and waveform computation for the coming edge
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    half_d       = half_q;
    phase_d      = phase_q;
    pend_half_d  = pend_half_q;
    pend_phase_d = pend_phase_q;
    ready_d      = cfg_ready;
    err_d        = 1'b0;
    ref_d        = 1'b0;
    phased_d     = 1'b0;
    start_d      = 1'b0;
    locked_d     = locked;
    apply        = 1'b0;
    cnt_nx       = '0;

    // Offered configuration: legal when H >= 1 and Ph < 2H
    cfg_ok = (cfg_half != '0) && (cfg_phase < {cfg_half, 1'b0});
    if (cfg_valid && cfg_ready) begin
      if (cfg_ok) begin
        pend_half_d  = cfg_half;
        pend_phase_d = cfg_phase;
        ready_d      = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // A pending setting exists exactly while cfg_ready is low
    pending = !cfg_ready;
    period  = {half_q, 1'b0};
    wrap    = (cnt_q == period - ONE);

    // Pending settings take effect while idle, or on the wrap edge in RUN
    unique case (state_q)
      IDLE: apply = pending;
      RUN: begin
        if (wrap) apply = pending;
        else      cnt_nx = cnt_q + ONE;
      end
      default: apply = 1'b0;
    endcase

    use_half   = apply ? pend_half_q  : half_q;
    use_phase  = apply ? pend_phase_q : phase_q;
    use_period = {use_half, 1'b0};

    // Position within the lagged waveform, folded back into 0..P-1
    diff = $signed({1'b0, cnt_nx}) - $signed({1'b0, use_phase});
    if (diff[CNT_W+1]) diff = diff + $signed({1'b0, use_period});

    if (apply) begin
      half_d  = pend_half_q;
      phase_d = pend_phase_q;
      ready_d = 1'b1;
    end

    if (!enable) begin
      // Stopping (or staying stopped): counter parked, waveforms low
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      state_d = RUN;
      cnt_d   = cnt_nx;
      ref_d   = (cnt_nx < {1'b0, use_half});
      start_d = (cnt_nx == '0);
      if (state_q == IDLE) begin
        // First cycle after start: the delayed copy has no history yet
        phased_d = (use_phase == '0);
        locked_d = 1'b0;
      end else begin
        phased_d = (diff < $signed({2'b00, use_half}));
        if (wrap) locked_d = !apply;
      end
    end
  end

  // State, settings and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      half_q       <= DEF_H;
      phase_q      <= DEF_P;
      pend_half_q  <= '0;
      pend_phase_q <= '0;
      cfg_ready    <= 1'b1;
      cfg_err      <= 1'b0;
      ref_clk      <= 1'b0;
      phased_clk   <= 1'b0;
      period_start <= 1'b0;
      locked       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      phase_q      <= phase_d;
      pend_half_q  <= pend_half_d;
      pend_phase_q <= pend_phase_d;
      cfg_ready    <= ready_d;
      cfg_err      <= err_d;
      ref_clk      <= ref_d;
      phased_clk   <= phased_d;
      period_start <= start_d;
      locked       <= locked_d;
    end
  end

endmodule

// File: tb/tb_clock_phase_gen.sv
// Directed bench for clock_phase_gen: default waveform, reconfiguration at a
// wrap, rejected settings, H=1 corner, stop with pending setting, mid-run reset.
module tb_clock_phase_gen;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CNT_W-1:0] cfg_half;
  logic [CNT_W:0]   cfg_phase;
  logic             cfg_err;
  logic             ref_clk;
  logic             phased_clk;
  logic             period_start;
  logic             locked;
  logic             state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {ref_clk, phased_clk, period_start, locked} per cycle
  logic [3:0] exp_q[$];

  clock_phase_gen #(.CNT_W(CNT_W), .DEF_HALF(4), .DEF_PHASE(0)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_half     (cfg_half),
    .cfg_phase    (cfg_phase),
    .cfg_err      (cfg_err),
    .ref_clk      (ref_clk),
    .phased_clk   (phased_clk),
    .period_start (period_start),
    .locked       (locked),
    .state_dbg    (state_dbg)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Run ncyc edges; cycle k lands on counter (c0+k)%p. Patterns are written
  // with cnt=0 as the most significant of the p used bits.
  task automatic run_check(input string tag, input int ncyc, input int p, input int c0,
                           input logic [7:0] ref_pat, input logic [7:0] ph_pat,
                           input int lock_from);
    logic [3:0] exp_v;
    for (int k = 0; k < ncyc; k++) begin
      int c;
      c = (c0 + k) % p;
      exp_q.push_back({ref_pat[p-1-c], ph_pat[p-1-c], (c == 0), (k >= lock_from)});
      step();
      exp_v = exp_q.pop_front();
      check($sformatf("%s ref k%0d", tag, k),    ref_clk,      exp_v[3]);
      check($sformatf("%s phased k%0d", tag, k), phased_clk,   exp_v[2]);
      check($sformatf("%s pstart k%0d", tag, k), period_start, exp_v[1]);
      check($sformatf("%s locked k%0d", tag, k), locked,       exp_v[0]);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " ref"},    ref_clk,      1'b0);
    check({tag, " phased"}, phased_clk,   1'b0);
    check({tag, " pstart"}, period_start, 1'b0);
    check({tag, " locked"}, locked,       1'b0);
    check({tag, " err"},    cfg_err,      1'b0);
    check({tag, " ready"},  cfg_ready,    1'b1);
    check({tag, " state"},  state_dbg,    1'b0);
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    cfg_valid = 1'b0;
    cfg_half  = '0;
    cfg_phase = '0;

    // 1: reset, idle, then default H=4 Ph=0 waveform
    step();
    step();
    check_reset_values("t1 rst");
    reset = 1'b0;
    step();
    check_reset_values("t1 idle");
    enable = 1'b1;
    run_check("t1", 16, 8, 0, 8'hF0, 8'hF0, 8);
    check("t1 state run", state_dbg, 1'b1);

    // 2: offer H=4 Ph=2 at cnt=3; takes effect at the next wrap
    run_check("t2a", 4, 8, 0, 8'hF0, 8'hF0, 0);
    cfg_valid = 1'b1; cfg_half = 8'd4; cfg_phase = 9'd2;
    step();
    check("t2 ready low", cfg_ready, 1'b0);
    check("t2 no err", cfg_err, 1'b0);
    check("t2 ref cnt4", ref_clk, 1'b0);
    cfg_half = 8'd0;   // offered while not ready: must be ignored
    step();
    check("t2 ignored err", cfg_err, 1'b0);
    check("t2 ignored ready", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    run_check("t2b", 2, 8, 6, 8'hF0, 8'hF0, 0);
    check("t2 ready before wrap", cfg_ready, 1'b0);
    run_check("t2c", 1, 8, 0, 8'hF0, 8'h3C, 1);
    check("t2 ready after wrap", cfg_ready, 1'b1);
    run_check("t2d", 15, 8, 1, 8'hF0, 8'h3C, 7);

    // 3: rejected settings (H=0, then Ph=2H)
    cfg_valid = 1'b1; cfg_half = 8'd0; cfg_phase = 9'd0;
    step();
    check("t3 err h0", cfg_err, 1'b1);
    check("t3 ready h0", cfg_ready, 1'b1);
    check("t3 ref h0", ref_clk, 1'b1);
    check("t3 locked h0", locked, 1'b1);
    cfg_valid = 1'b0;
    step();
    check("t3 err clear1", cfg_err, 1'b0);
    check("t3 phased cnt1", phased_clk, 1'b0);
    cfg_valid = 1'b1; cfg_half = 8'd4; cfg_phase = 9'd8;
    step();
    check("t3 err ph8", cfg_err, 1'b1);
    check("t3 ready ph8", cfg_ready, 1'b1);
    check("t3 phased cnt2", phased_clk, 1'b1);
    cfg_valid = 1'b0;
    step();
    check("t3 err clear2", cfg_err, 1'b0);
    run_check("t3", 8, 8, 4, 8'hF0, 8'h3C, 0);

    // 4: H=1 Ph=1 (largest legal phase for H=1)
    cfg_valid = 1'b1; cfg_half = 8'd1; cfg_phase = 9'd1;
    step();
    check("t4 ready low", cfg_ready, 1'b0);
    check("t4 no err", cfg_err, 1'b0);
    cfg_valid = 1'b0;
    run_check("t4a", 3, 8, 5, 8'hF0, 8'h3C, 0);
    run_check("t4b", 8, 2, 0, 8'h02, 8'h01, 2);
    check("t4 ready", cfg_ready, 1'b1);

    // 5: stop mid-period with H=3 Ph=1 pending, apply in idle, restart
    cfg_valid = 1'b1; cfg_half = 8'd3; cfg_phase = 9'd1;
    step();
    check("t5 ready low", cfg_ready, 1'b0);
    check("t5 pstart", period_start, 1'b1);
    cfg_valid = 1'b0;
    enable = 1'b0;
    step();
    check("t5 stop ref", ref_clk, 1'b0);
    check("t5 stop phased", phased_clk, 1'b0);
    check("t5 stop pstart", period_start, 1'b0);
    check("t5 stop locked", locked, 1'b0);
    check("t5 stop state", state_dbg, 1'b0);
    check("t5 stop ready", cfg_ready, 1'b0);
    step();
    check("t5 idle apply ready", cfg_ready, 1'b1);
    enable = 1'b1;
    run_check("t5", 12, 6, 0, 8'h38, 8'h1C, 6);

    // 6: reset mid-period with H=2 Ph=1 pending; defaults afterwards
    run_check("t6a", 2, 6, 0, 8'h38, 8'h1C, 0);
    cfg_valid = 1'b1; cfg_half = 8'd2; cfg_phase = 9'd1;
    step();
    check("t6 ready low", cfg_ready, 1'b0);
    cfg_valid = 1'b0;
    reset = 1'b1;
    step();
    check_reset_values("t6 rst");
    reset  = 1'b0;
    enable = 1'b0;
    step();
    check_reset_values("t6 idle");
    enable = 1'b1;
    run_check("t6b", 16, 8, 0, 8'hF0, 8'hF0, 8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clock_phase_gen.md
Name: clock_phase_gen

Overview:
Programmable divided-clock and phase-shift generator that sits directly upstream of the clock phasing stage and supplies its clock-like input. All logic runs on the single system clock. It produces a divided reference waveform (ref_clk) and a copy delayed by a programmable number of clk cycles (phased_clk). Divider and phase settings change only at period boundaries, so there are no glitches or runt pulses.

Parameters:
CNT_W, 8, width of the half-period setting; the period counter is CNT_W+1 bits wide.
DEF_HALF, 4, half-period in clk cycles loaded at reset; must be >= 1.
DEF_PHASE, 0, phase offset in clk cycles loaded at reset; must be < 2*DEF_HALF.

Ports:
clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous reset, active-high.
enable  input  1  run/stop control for waveform generation.
cfg_valid  input  1  a new configuration is offered.
cfg_ready  output  1  block can accept a configuration.
cfg_half  input  CNT_W  requested half-period H.
cfg_phase  input  CNT_W+1  requested phase lag Ph, in clk cycles.
cfg_err  output  1  one-cycle pulse when an offered configuration is rejected.
ref_clk  output  1  divided reference waveform: period 2H, 50% duty.
phased_clk  output  1  ref_clk delayed by Ph cycles (modulo 2H).
period_start  output  1  one-cycle pulse on the cycle the counter is 0.
locked  output  1  current settings have completed at least one full period.

Behaviour:
- Reset is synchronous and active-high; all outputs are registered.
- Reset values: ref_clk=0, phased_clk=0, period_start=0, locked=0, cfg_err=0, cfg_ready=1. Active settings load to H=DEF_HALF, Ph=DEF_PHASE. Counter cnt=0, state IDLE, pending configuration discarded.
- Period P = 2*H, computed at CNT_W+1 bits. cnt runs 0..P-1 and wraps to 0.
- States:
  - IDLE: cnt held at 0; ref_clk, phased_clk and period_start are 0; locked=0.
  - IDLE->RUN on an edge where enable=1: cnt<=0, ref_clk<=1, phased_clk<=(Ph==0), period_start<=1.
  - RUN: every edge advances cnt (cnt<=(cnt==P-1)?0:cnt+1).
    - ref_clk<=(cnt_next<H).
    - phased_clk<=(d<H), where d=cnt_next-Ph, plus P if the subtraction is negative. Use CNT_W+2-bit signed arithmetic.
    - period_start<=(cnt_next==0).
  - RUN->IDLE on an edge where enable=0: cnt<=0, all waveform outputs <=0, locked<=0, on that same edge.
- Config handshake:
  - A transfer happens when cfg_valid && cfg_ready on an edge.
  - A configuration is valid only if H>=1 and Ph<2H.
  - Invalid: cfg_err pulses for exactly one cycle on the next cycle; active and pending settings are unchanged; cfg_ready stays 1.
  - Valid: the configuration is stored as pending and cfg_ready<=0.
- Applying a pending configuration:
  - In RUN: on the wrap edge (cnt==P-1), the new H and Ph are used for the cnt_next=0 computation. cfg_ready<=1 and locked<=0 on the same edge.
  - In IDLE: applied on the edge after acceptance; cfg_ready returns to 1 on that edge.
- locked<=1 on the wrap edge that ends the first complete period run with unchanged settings. It stays 1 until a configuration is applied, enable drops, or reset.
- Simultaneous events:
  - enable falls on the wrap edge while a configuration is pending: go to IDLE and apply the pending configuration.
  - reset always has priority over every other event.
- Reset mid-operation: everything returns to the reset values on that edge, regardless of state or pending handshake.
- cfg_valid while cfg_ready=0 is ignored; it causes no error and no data is captured.

Test Plan:
1. Reset held 2 cycles, then released with enable=0 -> all outputs 0, cfg_ready=1; after enable=1, ref_clk pattern is 11110000 repeating, phased_clk identical, period_start every 8 cycles, locked=1 from the 9th RUN cycle.
2. In RUN with defaults, offer H=4, Ph=2 at cnt=3 -> cfg_ready=0 until the next wrap. After the wrap, phased_clk = 00111100 repeating (lag 2), locked=0 for 8 cycles then 1.
3. Offer H=0, then H=4 with Ph=8 -> cfg_err pulses 1 cycle each, waveforms unchanged, cfg_ready stays 1.
4. Configure H=1, Ph=1 -> ref_clk 1010..., phased_clk 0101..., period_start every 2 cycles.
5. Drop enable mid-period with a configuration pending -> outputs 0 on the next edge, locked=0. The configuration is applied in IDLE; re-enabling starts at cnt=0 with the new settings.
6. Assert reset mid-period with a configuration pending -> reset values on the next edge, pending configuration discarded, and defaults (H=4, Ph=0) used after re-enable.
